// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the arbitrated output multiplexer.
// Holds the arbitration-mode enum and the channel-index width function.
package arb_mux_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // Channel index width; never narrower than one bit.
  function automatic int unsigned cw(input int unsigned n);
    int unsigned w;
    w = unsigned'($clog2(n));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant generator: round-robin from a rotating pointer, or fixed lowest-index priority.
// The grant is purely combinational; only the pointer is stateful.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int unsigned NCh  = 4,
  parameter arb_mode_e   MODE = ARB_RR
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCh-1:0] req,
  input  logic           advance,
  output logic [NCh-1:0] gnt
);

  localparam int unsigned CW = cw(NCh);

  logic [CW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] gnt_idx;
  logic [CW-1:0] idx;
  logic [CW:0]   sum;
  logic          found;

  // Walk channels starting at the pointer (or at 0), wrapping past NCh-1.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    sum     = '0;
    for (int unsigned i = 0; i < NCh; i++) begin
      if (MODE == ARB_FIXED) begin
        sum = (CW+1)'(i);
      end else begin
        sum = {1'b0, ptr_q} + (CW+1)'(i);
        if (sum >= (CW+1)'(NCh)) begin
          sum = sum - (CW+1)'(NCh);
        end
      end
      idx = sum[CW-1:0];
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (MODE == ARB_FIXED) begin
      ptr_d = '0;
    end else if (advance && found) begin
      ptr_d = (gnt_idx == CW'(NCh - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-channel arbitrated mux into a single registered output stage.
// Accepts one word per cycle while downstream is ready; holds under backpressure.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int unsigned DSize = 32,
  parameter int unsigned NCh   = 4,
  parameter arb_mode_e   MODE  = ARB_RR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCh-1:0]       in_valid,
  input  logic [NCh*DSize-1:0] in_data,
  output logic [NCh-1:0]       in_ready,
  output logic                 out_valid,
  output logic [DSize-1:0]     out_data,
  output logic [cw(NCh)-1:0]   out_ch,
  input  logic                 out_ready
);

  localparam int unsigned CW = cw(NCh);

  logic             load;
  logic             xfer;
  logic [NCh-1:0]   gnt;
  logic [DSize-1:0] sel_data;
  logic [CW-1:0]    sel_ch;
  logic             out_valid_q;
  logic [DSize-1:0] out_data_q;
  logic [CW-1:0]    out_ch_q;

  assign load     = !out_valid_q | out_ready;
  assign xfer     = rst_n & load & (|in_valid);
  assign in_ready = gnt & {NCh{rst_n & load}};

  rr_arbiter #(
    .NCh  (NCh),
    .MODE (MODE)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (in_valid),
    .advance (xfer),
    .gnt     (gnt)
  );

  // Grant is one-hot, so OR-ing the masked slices is a clean select.
  always_comb begin
    sel_data = '0;
    sel_ch   = '0;
    for (int unsigned i = 0; i < NCh; i++) begin
      if (gnt[i]) begin
        sel_data = sel_data | in_data[i*DSize +: DSize];
        sel_ch   = sel_ch | CW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else if (load) begin
      if (|in_valid) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sel_data;
        out_ch_q    <= sel_ch;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: one round-robin and one fixed-priority instance on shared stimulus,
// checked against hand-derived vectors and a distance-based reference model.
module tb_arb_mux;
  import arb_mux_pkg::*;

  localparam int NCh   = 4;
  localparam int DSize = 32;

  logic                 clk;
  logic                 rst_n;
  logic [NCh-1:0]       in_valid;
  logic [NCh*DSize-1:0] in_data;
  logic                 out_ready;

  logic [NCh-1:0]   rdy_rr, rdy_fx;
  logic             ov_rr, ov_fx;
  logic [DSize-1:0] od_rr, od_fx;
  logic [1:0]       oc_rr, oc_fx;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state, index 0 = round-robin, 1 = fixed priority.
  logic             mv[2];
  logic [DSize-1:0] md[2];
  int               mc[2];
  int               mp[2];
  int               mg[2];
  logic [NCh-1:0]   cap_rdy[2];

  typedef struct {
    logic           r;
    logic [NCh-1:0] v;
    logic           o;
    logic [NCh-1:0] rr_rdy;
    logic           ov;
    logic [1:0]     rr_ch;
    logic [NCh-1:0] fx_rdy;
    logic [1:0]     fx_ch;
  } vec_t;

  vec_t tbl[17];

  arb_mux #(.DSize(DSize), .NCh(NCh), .MODE(ARB_RR)) dut_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (rdy_rr),
    .out_valid (ov_rr),
    .out_data  (od_rr),
    .out_ch    (oc_rr),
    .out_ready (out_ready)
  );

  arb_mux #(.DSize(DSize), .NCh(NCh), .MODE(ARB_FIXED)) dut_fx (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (rdy_fx),
    .out_valid (ov_fx),
    .out_data  (od_fx),
    .out_ch    (oc_fx),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Winner is the requester closest to the pointer going upward (RR) or the lowest index.
  function automatic int grant_of(input int m, input logic [NCh-1:0] v, input int p);
    int best, bestd, d;
    best  = -1;
    bestd = NCh;
    for (int i = 0; i < NCh; i++) begin
      if (v[i]) begin
        d = (m == 0) ? (i - p + NCh) % NCh : i;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [NCh*DSize-1:0] rand_data();
    logic [NCh*DSize-1:0] d;
    for (int i = 0; i < NCh; i++) d[i*DSize +: DSize] = $urandom;
    return d;
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic r, input logic [NCh-1:0] v, input logic o,
                      input logic [NCh*DSize-1:0] d);
    logic [NCh-1:0] er;
    logic           ld;
    rst_n     = r;
    in_valid  = v;
    out_ready = o;
    in_data   = d;
    #1;
    cap_rdy[0] = rdy_rr;
    cap_rdy[1] = rdy_fx;
    for (int m = 0; m < 2; m++) begin
      mg[m] = grant_of(m, v, mp[m]);
      ld    = !mv[m] || o;
      er    = (r && ld && mg[m] >= 0) ? NCh'(1 << mg[m]) : '0;
      check($sformatf("m%0d in_ready", m), 64'(cap_rdy[m]), 64'(er));
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (!r) begin
        mv[m] = 1'b0;
        md[m] = '0;
        mc[m] = 0;
        mp[m] = 0;
      end else if (!mv[m] || o) begin
        if (mg[m] >= 0) begin
          mv[m] = 1'b1;
          md[m] = d[mg[m]*DSize +: DSize];
          mc[m] = mg[m];
          if (m == 0) mp[m] = (mg[m] + 1) % NCh;
        end else begin
          mv[m] = 1'b0;
        end
      end
    end
    #1;
    check("m0 out_valid", 64'(ov_rr), 64'(mv[0]));
    check("m0 out_ch",    64'(oc_rr), 64'(mc[0]));
    check("m0 out_data",  64'(od_rr), 64'(md[0]));
    check("m1 out_valid", 64'(ov_fx), 64'(mv[1]));
    check("m1 out_ch",    64'(oc_fx), 64'(mc[1]));
    check("m1 out_data",  64'(od_fx), 64'(md[1]));
    @(negedge clk);
  endtask

  initial begin
    logic [NCh*DSize-1:0] d;
    logic                 r, o;
    logic [NCh-1:0]       v;

    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    for (int m = 0; m < 2; m++) begin
      mv[m] = 1'b0;
      md[m] = '0;
      mc[m] = 0;
      mp[m] = 0;
    end

    // r, v, o, rr_rdy, ov, rr_ch, fx_rdy, fx_ch
    tbl[0]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000, 2'd0};
    tbl[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000, 2'd0};
    tbl[2]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'b0001, 2'd0};
    tbl[3]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 4'b0001, 2'd0};
    tbl[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 4'b0001, 2'd0};
    tbl[5]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 4'b0001, 2'd0};
    tbl[6]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'b0001, 2'd0};
    tbl[7]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 4'b0001, 2'd0};
    tbl[8]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 4'b0001, 2'd0};
    tbl[9]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 4'b0001, 2'd0};
    tbl[10] = '{1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 4'b0100, 2'd2};
    tbl[11] = '{1'b1, 4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1, 4'b0010, 2'd1};
    tbl[12] = '{1'b1, 4'b0110, 1'b1, 4'b0100, 1'b1, 2'd2, 4'b0010, 2'd1};
    tbl[13] = '{1'b1, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 4'b0010, 2'd1};
    tbl[14] = '{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 4'b0010, 2'd1};
    tbl[15] = '{1'b1, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 4'b0010, 2'd1};
    tbl[16] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 4'b0000, 2'd1};

    @(negedge clk);
    for (int k = 0; k < 17; k++) begin
      step(tbl[k].r, tbl[k].v, tbl[k].o, rand_data());
      check($sformatf("vec%0d rr in_ready", k), 64'(cap_rdy[0]), 64'(tbl[k].rr_rdy));
      check($sformatf("vec%0d rr out_valid", k), 64'(ov_rr), 64'(tbl[k].ov));
      check($sformatf("vec%0d rr out_ch", k), 64'(oc_rr), 64'(tbl[k].rr_ch));
      check($sformatf("vec%0d fx in_ready", k), 64'(cap_rdy[1]), 64'(tbl[k].fx_rdy));
      check($sformatf("vec%0d fx out_valid", k), 64'(ov_fx), 64'(tbl[k].ov));
      check($sformatf("vec%0d fx out_ch", k), 64'(oc_fx), 64'(tbl[k].fx_ch));
    end

    // Backpressure: word from channel 1 held for three stalled cycles.
    d = rand_data();
    d[1*DSize +: DSize] = 32'hA5A5_0001;
    step(1'b1, 4'b0010, 1'b1, d);
    check("bp load data", 64'(od_rr), 64'h0000_0000_A5A5_0001);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 4'b1111, 1'b0, rand_data());
      check("bp rr in_ready", 64'(cap_rdy[0]), 64'h0);
      check("bp fx in_ready", 64'(cap_rdy[1]), 64'h0);
      check("bp data stable", 64'(od_rr), 64'h0000_0000_A5A5_0001);
      check("bp ch stable", 64'(oc_rr), 64'd1);
    end
    d = rand_data();
    step(1'b1, 4'b1111, 1'b1, d);
    check("bp release rr in_ready", 64'(cap_rdy[0]), 64'b0100);
    check("bp release rr ch", 64'(oc_rr), 64'd2);
    check("bp release rr data", 64'(od_rr), 64'(d[2*DSize +: DSize]));
    check("bp release fx ch", 64'(oc_fx), 64'd0);

    // Reset while a stalled word is held: it must vanish.
    step(1'b1, 4'b1111, 1'b0, rand_data());
    check("pre-reset held", 64'(ov_rr), 64'd1);
    step(1'b0, 4'b1111, 1'b0, rand_data());
    check("mid reset in_ready", 64'(cap_rdy[0]), 64'h0);
    check("mid reset out_valid", 64'(ov_rr), 64'd0);
    check("mid reset out_data", 64'(od_rr), 64'h0);
    step(1'b1, 4'b0000, 1'b1, rand_data());
    check("post reset idle", 64'(ov_rr), 64'd0);
    step(1'b1, 4'b1111, 1'b1, rand_data());
    check("post reset first grant", 64'(oc_rr), 64'd0);
    check("post reset first ready", 64'(cap_rdy[0]), 64'b0001);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      r = ($urandom_range(0, 49) != 0);
      v = NCh'($urandom);
      o = ($urandom_range(0, 3) != 0);
      step(r, v, o, rand_data());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL have parameter DSize, default 32, meaning the data width in bits per channel.
REQ-002 SHALL have parameter NCh, default 4, meaning the number of input channels; legal range 2..16.
REQ-003 SHALL have parameter MODE, default 0, meaning the arbitration mode: 0 = round-robin, 1 = fixed priority with the lowest index winning.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port in_valid, input, NCh bits: per-channel request.
REQ-007 SHALL have port in_data, input, NCh*DSize bits: packed channel data; channel i occupies [i*DSize +: DSize].
REQ-008 SHALL have port in_ready, output, NCh bits: per-channel accept; one-hot or zero.
REQ-009 SHALL have port out_valid, output, 1 bit: output register holds a word.
REQ-010 SHALL have port out_data, output, DSize bits: registered selected data.
REQ-011 SHALL have port out_ch, output, CW = max(1, $clog2(NCh)) bits: source channel index of out_data.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accept.

Function
REQ-013 SHALL define load = !out_valid | out_ready, meaning the output register may accept a word this cycle.
REQ-014 SHALL compute grant g combinationally from in_valid and, in MODE 0, the priority pointer ptr.
REQ-015 SHALL assert in_ready[g] = load only for the granted channel; all other in_ready bits SHALL be 0.
REQ-016 SHALL treat a transfer on channel i as in_valid[i] & in_ready[i] at a rising edge.
REQ-017 SHALL, when load is 1 and any in_valid bit is 1, register out_data <= in_data[g], out_ch <= g and out_valid <= 1; latency is 1 cycle from input transfer to out_valid.
REQ-018 SHALL, when load is 1 and in_valid is all-zero, register out_valid <= 0 and leave out_data and out_ch unchanged.
REQ-019 SHALL, when load is 0 (out_valid & !out_ready), hold out_valid, out_data and out_ch stable and drive in_ready to all-zero.
REQ-020 SHALL sustain 1 word/cycle throughput while out_ready is held 1, with no bubble between consecutive grants.
REQ-021 SHALL, in MODE 0, search from channel ptr upward with wrap-around; the first requesting channel wins.
REQ-022 SHALL, in MODE 0, update ptr <= (g+1) mod NCh on each transfer; channel NCh-1 wraps to 0; ptr is unchanged on cycles without a transfer.
REQ-023 SHALL, in MODE 1, grant the lowest requesting index; ptr is held at 0 and unused.
REQ-024 SHALL let a channel that deasserts in_valid before transfer simply lose its grant, with no state change.
REQ-025 SHALL, on simultaneous out_ready consumption and a new input transfer in one cycle, replace the word without a gap.

Reset
REQ-026 SHALL, while rst_n = 0 at a rising edge, set out_valid = 0, out_data = 0, out_ch = 0 and ptr = 0.
REQ-027 SHALL drive in_ready to all-zero in any cycle where rst_n = 0.
REQ-028 SHALL discard a word held in the output register when reset is asserted mid-operation; it is never presented after reset.

Structure
REQ-029 SHALL place the arbitration-mode enum (ARB_RR = 0, ARB_FIXED = 1) and the CW width function in shared package arb_mux_pkg.
REQ-030 SHALL implement grant and pointer logic in sub-module rr_arbiter (parameters NCh, MODE; ports clk, rst_n, req, advance, gnt one-hot); arb_mux holds the output register and data select.

Verification
REQ-031 SHALL cover reset: rst_n = 0 with in_valid = 4'b1111 -> in_ready = 0 and out_valid = 0; after release, first grant goes to channel 0.
REQ-032 SHALL cover round-robin: NCh = 4, MODE 0, in_valid = 4'b1111, out_ready = 1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with out_valid continuously 1.
REQ-033 SHALL cover backpressure: out_valid = 1, out_data = 32'hA5A5_0001, out_ready = 0 for 3 cycles -> out_data and out_ch stable and in_ready = 0; on out_ready = 1, the next word loads the same cycle.
REQ-034 SHALL cover fixed priority: MODE 1, in_valid = 4'b1010 held -> channel 1 always granted and channel 3 starved.
REQ-035 SHALL cover wrap and skip: MODE 0, ptr = 3, in_valid = 4'b0110 -> grant 1, then ptr = 2 and next grant 2.
REQ-036 SHALL cover reset mid-operation: out_valid = 1, out_ready = 0, rst_n pulsed low for 1 cycle -> out_valid = 0, ptr = 0, and the old data is never transferred.
